// File: rtl/logic_rs_pkg.sv
// Shared types and constants for the logic-unit reservation station.
package logic_rs_pkg;

  localparam int unsigned RS_ENTRIES = 4;
  localparam int unsigned RS_TAG_W   = 4;
  localparam int unsigned RS_DATA_W  = 64;
  localparam int unsigned OP_W       = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_NEG  = 3'd6;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd7;

  // Unary ops never read operand b.
  function automatic logic uses_b(input logic [OP_W-1:0] opcode);
    return !((opcode == OP_NOT) || (opcode == OP_NEG));
  endfunction

  // One station slot; a slot is READY when valid with both operands ready.
  typedef struct packed {
    logic                 valid;
    logic [OP_W-1:0]      opcode;
    logic [RS_TAG_W-1:0]  dest;
    logic                 a_rdy;
    logic                 b_rdy;
    logic [RS_TAG_W-1:0]  a_tag;
    logic [RS_TAG_W-1:0]  b_tag;
    logic [RS_DATA_W-1:0] a_val;
    logic [RS_DATA_W-1:0] b_val;
  } rs_entry_t;

endpackage

// File: rtl/logic_rs_select.sv
// Issue picker: ready vector -> one-hot grant and index.
// LOGIC_RS_AGE_ORDER_EN: oldest ready entry wins (age matrix, i_age[i][j]=1 means i older than j);
// otherwise the lowest-index ready entry wins.
module logic_rs_select
  #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
  )
  (
    input  logic [ENTRIES-1:0]              i_ready,
`ifdef LOGIC_RS_AGE_ORDER_EN
    input  logic [ENTRIES-1:0][ENTRIES-1:0] i_age,
`endif
    output logic [ENTRIES-1:0]              o_grant_c,
    output logic [IDX_W-1:0]                o_idx_c,
    output logic                            o_any_c
  );

  // Pick one ready entry and encode its index.
  always_comb begin
`ifdef LOGIC_RS_AGE_ORDER_EN
    logic v_blocked;
`else
    logic v_found;
`endif
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = |i_ready;
`ifdef LOGIC_RS_AGE_ORDER_EN
    v_blocked = 1'b0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      v_blocked = 1'b0;
      for (int j = 0; j < int'(ENTRIES); j++) begin
        if ((j != i) && i_ready[j] && i_age[j][i]) v_blocked = 1'b1;
      end
      if (i_ready[i] && !v_blocked) o_grant_c[i] = 1'b1;
    end
`else
    v_found = 1'b0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (i_ready[i] && !v_found) begin
        o_grant_c[i] = 1'b1;
        v_found      = 1'b1;
      end
    end
`endif
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (o_grant_c[i]) o_idx_c = IDX_W'(i);
    end
  end

endmodule

// File: rtl/logic_rs.sv
// Reservation station in front of the 64-bit logic unit: buffers dispatched ops,
// snoops the CDB for pending operands, issues one ready op per cycle.
// Optional macro LOGIC_RS_AGE_ORDER_EN selects oldest-first issue (age matrix);
// default build issues lowest-index first. TAG_W/DATA_W must match the package widths.
module logic_rs
  import logic_rs_pkg::*;
  #(
    parameter int unsigned ENTRIES = RS_ENTRIES,
    parameter int unsigned TAG_W   = RS_TAG_W,
    parameter int unsigned DATA_W  = RS_DATA_W,
    localparam int unsigned IDX_W  = $clog2(ENTRIES),
    localparam int unsigned OCC_W  = $clog2(ENTRIES + 1)
  )
  (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [OP_W-1:0]   disp_opcode,
    input  logic [TAG_W-1:0]  disp_dest,
    input  logic              disp_a_rdy,
    input  logic [DATA_W-1:0] disp_a_val,
    input  logic [TAG_W-1:0]  disp_a_tag,
    input  logic              disp_b_rdy,
    input  logic [DATA_W-1:0] disp_b_val,
    input  logic [TAG_W-1:0]  disp_b_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [OP_W-1:0]   iss_opcode,
    output logic [DATA_W-1:0] iss_a,
    output logic [DATA_W-1:0] iss_b,
    output logic [TAG_W-1:0]  iss_dest,
    output logic [OCC_W-1:0]  occupancy
  );

  rs_entry_t          r_ent [ENTRIES];
  logic [OCC_W-1:0]   r_occ;
  logic               r_lock;
  logic [IDX_W-1:0]   r_lock_idx;

  logic [ENTRIES-1:0] w_ready;
  logic [ENTRIES-1:0] w_grant;
  logic [ENTRIES-1:0] w_iss_sel;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [IDX_W-1:0]   w_iss_idx;
  logic [IDX_W-1:0]   w_disp_idx;
  logic               w_pick_any;
  logic               w_iss_any;
  logic               w_iss_fire;
  logic               w_disp_fire;
  rs_entry_t          w_new;

`ifdef LOGIC_RS_AGE_ORDER_EN
  logic [ENTRIES-1:0][ENTRIES-1:0] r_age;
`endif

  // Per-entry readiness and lowest-index free slot for dispatch.
  always_comb begin
    logic v_found;
    w_ready    = '0;
    w_disp_idx = '0;
    v_found    = 1'b0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      w_ready[i] = r_ent[i].valid && r_ent[i].a_rdy && r_ent[i].b_rdy;
      if (!r_ent[i].valid && !v_found) begin
        w_disp_idx = IDX_W'(i);
        v_found    = 1'b1;
      end
    end
  end

  logic_rs_select #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_select (
    .i_ready   (w_ready),
`ifdef LOGIC_RS_AGE_ORDER_EN
    .i_age     (r_age),
`endif
    .o_grant_c (w_grant),
    .o_idx_c   (w_pick_idx),
    .o_any_c   (w_pick_any)
  );

  // A stalled offer stays locked on its entry until the unit accepts it.
  assign w_iss_any   = r_lock || w_pick_any;
  assign w_iss_idx   = r_lock ? r_lock_idx : w_pick_idx;
  assign iss_valid   = w_iss_any && !rst;
  assign w_iss_fire  = iss_valid && iss_ready;
  assign iss_opcode  = iss_valid ? r_ent[w_iss_idx].opcode : '0;
  assign iss_a       = iss_valid ? r_ent[w_iss_idx].a_val  : '0;
  assign iss_b       = iss_valid ? r_ent[w_iss_idx].b_val  : '0;
  assign iss_dest    = iss_valid ? r_ent[w_iss_idx].dest   : '0;

  assign disp_ready  = (r_occ < OCC_W'(ENTRIES));
  assign w_disp_fire = disp_valid && disp_ready;
  assign occupancy   = r_occ;

  // One-hot of the entry being offered this cycle.
  always_comb begin
    w_iss_sel = w_grant;
    if (r_lock) begin
      w_iss_sel = '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (r_lock_idx == IDX_W'(i)) w_iss_sel[i] = 1'b1;
      end
    end
  end

  // New entry image, including same-cycle CDB capture for pending operands.
  always_comb begin
    w_new        = '0;
    w_new.valid  = 1'b1;
    w_new.opcode = disp_opcode;
    w_new.dest   = disp_dest;
    if (disp_a_rdy) begin
      w_new.a_rdy = 1'b1;
      w_new.a_val = disp_a_val;
    end else if (cdb_valid && (cdb_tag == disp_a_tag)) begin
      w_new.a_rdy = 1'b1;
      w_new.a_val = cdb_data;
    end else begin
      w_new.a_tag = disp_a_tag;
    end
    if (!uses_b(disp_opcode) || disp_b_rdy) begin
      w_new.b_rdy = 1'b1;
      w_new.b_val = uses_b(disp_opcode) ? disp_b_val : '0;
    end else if (cdb_valid && (cdb_tag == disp_b_tag)) begin
      w_new.b_rdy = 1'b1;
      w_new.b_val = cdb_data;
    end else begin
      w_new.b_tag = disp_b_tag;
    end
  end

  // Entry array: dispatch write, issue free, CDB wakeup; plus occupancy and issue lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) r_ent[i] <= '0;
      r_occ      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (w_disp_fire && (w_disp_idx == IDX_W'(i))) begin
          r_ent[i] <= w_new;
        end else begin
          if (w_iss_fire && w_iss_sel[i]) r_ent[i].valid <= 1'b0;
          if (cdb_valid && r_ent[i].valid && !r_ent[i].a_rdy && (r_ent[i].a_tag == cdb_tag)) begin
            r_ent[i].a_rdy <= 1'b1;
            r_ent[i].a_val <= cdb_data;
          end
          if (cdb_valid && r_ent[i].valid && !r_ent[i].b_rdy && (r_ent[i].b_tag == cdb_tag)) begin
            r_ent[i].b_rdy <= 1'b1;
            r_ent[i].b_val <= cdb_data;
          end
        end
      end
      r_occ      <= r_occ + OCC_W'(w_disp_fire) - OCC_W'(w_iss_fire);
      r_lock     <= w_iss_any && !iss_ready;
      r_lock_idx <= w_iss_idx;
    end
  end

`ifdef LOGIC_RS_AGE_ORDER_EN
  // Age matrix: a newly dispatched entry is younger than every other entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= '0;
    end else if (w_disp_fire) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        for (int j = 0; j < int'(ENTRIES); j++) begin
          if (w_disp_idx == IDX_W'(i))      r_age[i][j] <= 1'b0;
          else if (w_disp_idx == IDX_W'(j)) r_age[i][j] <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
